// File: rtl/phase_scheduler_if.sv
// Signal bundle between the phase scheduler and its controller/display side.
// Inputs: TICK, AS, BS, PED_REQ. Outputs: phase state, counters and pulses.
interface phase_scheduler_if;
    logic       TICK;
    logic       AS;
    logic       BS;
    logic       PED_REQ;
    logic [3:0] state;
    logic [5:0] cnt;
    logic [5:0] A_time;
    logic [5:0] B_time;
    logic       PHASE_END;
    logic       PED_ACK;

    modport master (
        output TICK, AS, BS, PED_REQ,
        input  state, cnt, A_time, B_time, PHASE_END, PED_ACK
    );

    modport slave (
        input  TICK, AS, BS, PED_REQ,
        output state, cnt, A_time, B_time, PHASE_END, PED_ACK
    );
endinterface

// File: rtl/phase_scheduler.sv
// Shared-counter phase sequencer for the A/B crossing with gap-out.
// Optional all-red pedestrian phase S8 is built when PED_PHASE_EN is defined.
module phase_scheduler #(
    parameter int G_A_STR   = 27,
    parameter int G_A_LEFT  = 12,
    parameter int G_B_STR   = 17,
    parameter int G_B_LEFT  = 7,
    parameter int Y_TIME    = 3,
    parameter int PED_TIME  = 10,
    parameter int MIN_GREEN = 5
) (
    input logic              CLK,
    input logic              RSTn,
    phase_scheduler_if.slave bus
);
    typedef enum logic [3:0] {
        S0 = 4'd0, S1 = 4'd1, S2 = 4'd2,
        S3 = 4'd3, S4 = 4'd4, S5 = 4'd5,
        S6 = 4'd6, S7 = 4'd7, S8 = 4'd8
    } phase_t;

    // Zero-length durations are stretched to one tick.
    localparam logic [5:0] D_AS =
        (G_A_STR == 0) ? 6'd1 : 6'(G_A_STR);
    localparam logic [5:0] D_AL =
        (G_A_LEFT == 0) ? 6'd1 : 6'(G_A_LEFT);
    localparam logic [5:0] D_BS =
        (G_B_STR == 0) ? 6'd1 : 6'(G_B_STR);
    localparam logic [5:0] D_BL =
        (G_B_LEFT == 0) ? 6'd1 : 6'(G_B_LEFT);
    localparam logic [5:0] D_Y =
        (Y_TIME == 0) ? 6'd1 : 6'(Y_TIME);
    localparam logic [5:0] D_PED =
        (PED_TIME == 0) ? 6'd1 : 6'(PED_TIME);
    localparam logic [7:0] MG = 8'(MIN_GREEN);
    localparam logic [7:0] Y8 = {2'b00, D_Y};
    localparam logic [7:0] AL8 = {2'b00, D_AL};
    localparam logic [7:0] BL8 = {2'b00, D_BL};
`ifdef PED_PHASE_EN
    localparam logic [3:0] LAST = 4'd8;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif

    function automatic logic [5:0] dur(input phase_t s);
        case (s)
            S0:      dur = D_AS;
            S2:      dur = D_AL;
            S4:      dur = D_BS;
            S6:      dur = D_BL;
            S8:      dur = D_PED;
            default: dur = D_Y;
        endcase
    endfunction

    phase_t     state_q, state_n, nxt;
    logic [5:0] cnt_q, cnt_n;
    logic       pe_q;
    logic       legal;
    logic       gap;
    logic       ped_go;
    logic [7:0] p_add;
    logic [7:0] a_sum, b_sum;
    logic [7:0] elapsed_ok;

`ifdef PED_PHASE_EN
    logic req_q, pend_q, pend_n, ack_q;
    logic ped_edge, enter_ped;

    assign ped_edge  = bus.PED_REQ & ~req_q;
    assign ped_go    = pend_q | ped_edge;
    assign enter_ped = (state_n == S8) && (state_q != S8);
    assign pend_n    = enter_ped ? 1'b0 :
                       ped_edge  ? 1'b1 : pend_q;
    assign p_add     = pend_q ? {2'b00, D_PED} : 8'd0;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            req_q  <= bus.PED_REQ;
            pend_q <= pend_n;
            ack_q  <= enter_ped;
        end
    end

    assign bus.PED_ACK = ack_q;
`else
    logic unused_ped;

    assign unused_ped  = bus.PED_REQ;
    assign ped_go      = 1'b0;
    assign p_add       = 8'd0;
    assign bus.PED_ACK = 1'b0;
`endif

    assign legal = (state_q <= LAST);

    // Elapsed ticks D-cnt compared without risking underflow.
    assign elapsed_ok = {2'b00, cnt_q} + MG;
    assign gap = bus.TICK &&
                 ({2'b00, dur(state_q)} >= elapsed_ok) &&
                 (((state_q == S0) && !bus.AS && bus.BS) ||
                  ((state_q == S4) && bus.AS && !bus.BS));

    always_comb begin
        nxt = S0;
        case (state_q)
            S0:      nxt = S1;
            S1:      nxt = S2;
            S2:      nxt = S3;
            S3:      nxt = S4;
            S4:      nxt = S5;
            S5:      nxt = S6;
            S6:      nxt = S7;
            S7:      nxt = ped_go ? S8 : S0;
            default: nxt = S0;
        endcase
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        if (!legal) begin
            state_n = S0;
            cnt_n   = D_AS;
        end else if (bus.TICK) begin
            if (cnt_q <= 6'd1 || gap) begin
                state_n = nxt;
                cnt_n   = dur(nxt);
            end else begin
                cnt_n = cnt_q - 6'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S0;
            cnt_q   <= D_AS;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            pe_q    <= (state_n != state_q);
        end
    end

    always_comb begin
        a_sum = {2'b00, cnt_q};
        b_sum = {2'b00, cnt_q};
        case (state_q)
            S0: b_sum = a_sum + Y8 + Y8 + AL8 + p_add;
            S1: b_sum = a_sum + Y8 + AL8 + p_add;
            S2: b_sum = a_sum + Y8 + p_add;
            S3: b_sum = a_sum + p_add;
            S4: a_sum = b_sum + Y8 + Y8 + BL8 + p_add;
            S5: a_sum = b_sum + Y8 + BL8 + p_add;
            S6: a_sum = b_sum + Y8 + p_add;
            S7: a_sum = b_sum + p_add;
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.cnt       = cnt_q;
    assign bus.A_time    = (a_sum > 8'd63) ? 6'd63 : a_sum[5:0];
    assign bus.B_time    = (b_sum > 8'd63) ? 6'd63 : b_sum[5:0];
    assign bus.PHASE_END = pe_q;
endmodule

// File: tb/tb_phase_scheduler.sv
// Randomised and directed bench for phase_scheduler against a phase-table model.
// Expectations follow the PED_PHASE_EN setting of the build.
module tb_phase_scheduler;
    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    phase_scheduler_if bus();

    phase_scheduler dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    int dur [9] = '{27, 3, 12, 3, 17, 3, 7, 3, 10};
    int m_ph, m_rem;
    bit m_pend, m_prev, m_pe, m_ack;
    bit req;
    int pe_seen, ack_seen;

`ifdef PED_PHASE_EN
    localparam int PED = 1;
`else
    localparam int PED = 0;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0;
        m_rem = dur[0];
        m_pend = 0;
        m_prev = 0;
        m_pe = 0;
        m_ack = 0;
    endtask

    task automatic model_step(input bit t, input bit a,
                              input bit b, input bit r);
        bit rise, done;
        int e, nx;
        rise = (PED != 0) && r && !m_prev;
        m_prev = r;
        m_pe = 0;
        m_ack = 0;
        if (t) begin
            e = dur[m_ph] - m_rem;
            done = (m_rem == 1) ||
                   (m_ph == 0 && !a && b && e >= 5) ||
                   (m_ph == 4 && a && !b && e >= 5);
            if (done) begin
                if (m_ph == 7 && (m_pend || rise)) nx = 8;
                else if (m_ph >= 7) nx = 0;
                else nx = m_ph + 1;
                m_ph = nx;
                m_rem = dur[nx];
                m_pe = 1;
                if (nx == 8) begin
                    m_ack = 1;
                    m_pend = 0;
                    rise = 0;
                end
            end else begin
                m_rem--;
            end
        end
        if (rise) m_pend = 1;
    endtask

    // Time until a road's signal changes: own group -> this phase,
    // other group -> rest of the opposing group plus pending walk.
    function automatic int exp_time(input bit road_b);
        int s, last;
        if (m_ph == 8) return m_rem;
        if ((m_ph < 4) == !road_b) return m_rem;
        last = (m_ph < 4) ? 3 : 7;
        s = m_rem;
        for (int k = m_ph + 1; k <= last; k++) s += dur[k];
        if (m_pend) s += 10;
        return (s > 63) ? 63 : s;
    endfunction

    task automatic check_all();
        chk("state", int'(bus.state), m_ph);
        chk("cnt", int'(bus.cnt), m_rem);
        chk("A_time", int'(bus.A_time), exp_time(1'b0));
        chk("B_time", int'(bus.B_time), exp_time(1'b1));
        chk("PHASE_END", int'(bus.PHASE_END), int'(m_pe));
        chk("PED_ACK", int'(bus.PED_ACK), int'(m_ack));
    endtask

    task automatic cyc(input bit t, input bit a,
                       input bit b, input bit r);
        @(negedge CLK);
        bus.TICK = t;
        bus.AS = a;
        bus.BS = b;
        bus.PED_REQ = r;
        @(posedge CLK);
        model_step(t, a, b, r);
        #1;
        check_all();
        if (bus.PHASE_END) pe_seen++;
        if (bus.PED_ACK) ack_seen++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        bus.TICK = 0;
        bus.AS = 1;
        bus.BS = 1;
        bus.PED_REQ = 0;
        req = 0;
        RSTn = 0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RSTn = 1;
    endtask

    task automatic tick_until(input int p, input int r);
        for (int i = 0; i < 400; i++) begin
            if (m_ph == p && m_rem == r) break;
            cyc(1, 1, 1, req);
            cyc(0, 1, 1, req);
        end
        chk("reach_state", int'(bus.state), p);
        chk("reach_cnt", int'(bus.cnt), r);
    endtask

    initial begin
        bus.TICK = 0;
        bus.AS = 1;
        bus.BS = 1;
        bus.PED_REQ = 0;
        req = 0;
        model_reset();

        // Reset values and a full 75-tick cycle.
        do_reset();
        chk("rst_A", int'(bus.A_time), 27);
        chk("rst_B", int'(bus.B_time), 45);
        pe_seen = 0;
        for (int i = 0; i < 75; i++) begin
            cyc(1, 1, 1, 0);
            cyc(0, 1, 1, 0);
        end
        chk("cycle_pe", pe_seen, 8);
        chk("cycle_state", int'(bus.state), 0);
        chk("cycle_cnt", int'(bus.cnt), 27);

        // Gap-out of S0 after MIN_GREEN elapsed ticks.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);
        chk("gap_hold", int'(bus.state), 0);
        cyc(1, 0, 1, 0);
        chk("gap_state", int'(bus.state), 1);
        chk("gap_cnt", int'(bus.cnt), 3);

        // Request raised during S2.
        do_reset();
        tick_until(2, 12);
        req = 1;
        cyc(0, 1, 1, req);
        chk("ped_jump", int'(bus.B_time), 15 + 10 * PED);
        ack_seen = 0;
        tick_until(7, 1);
        cyc(1, 1, 1, req);
        chk("s7_exit", int'(bus.state), 8 * PED);
        chk("ack_once", ack_seen, PED);
        if (PED != 0) begin
            for (int i = 0; i < 9; i++) cyc(1, 1, 1, req);
            chk("s8_hold", int'(bus.state), 8);
            cyc(1, 1, 1, req);
            chk("s8_done", int'(bus.state), 0);
        end

        // Edge on the final S7 tick, then an edge inside S8.
        req = 0;
        cyc(0, 1, 1, req);
        tick_until(7, 1);
        req = 1;
        cyc(1, 1, 1, req);
        chk("late_edge", int'(bus.state), 8 * PED);
        req = 0;
        cyc(0, 1, 1, req);
        req = 1;
        cyc(0, 1, 1, req);
        tick_until(7, 1);
        cyc(1, 1, 1, req);
        chk("s8_again", int'(bus.state), 8 * PED);

        // Asynchronous reset in the middle of S4.
        do_reset();
        tick_until(4, 9);
        @(negedge CLK);
        #2;
        RSTn = 0;
        #1;
        model_reset();
        req = 0;
        chk("mid_state", int'(bus.state), 0);
        chk("mid_cnt", int'(bus.cnt), 27);
        chk("mid_A", int'(bus.A_time), 27);
        chk("mid_B", int'(bus.B_time), 45);
        check_all();
        @(negedge CLK);
        bus.PED_REQ = 0;
        RSTn = 1;
        cyc(1, 1, 1, 0);
        chk("post_rst_cnt", int'(bus.cnt), 26);

        // Random traffic, ticks and push-button activity.
        ack_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) req = ~req;
            cyc(bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 3) != 0),
                bit'($urandom_range(0, 3) != 0),
                req);
        end
        if (PED == 0) chk("no_ack", ack_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
